uart_comm: RTL

UART_COMM -- requirements
Module: uart_comm

---
 rtl/uart_comm_pkg.sv | 15 +
 rtl/uart_trx.sv | 161 ++++++++++++++++
 rtl/uart_comm.sv | 108 ++++++++++
 3 files changed

// File: rtl/uart_comm_pkg.sv
// Shared types and constants for the UART command link.
package uart_comm_pkg;

    localparam int unsigned DEF_BAUD_DIV     = 434;
    localparam int unsigned DEF_TIMEOUT_BITS = 32;
    localparam int unsigned BAUD_W           = 12;

    localparam logic [1:0] CMD_BYTE_HI  = 2'd0;
    localparam logic [1:0] CMD_BYTE_MID = 2'd1;
    localparam logic [1:0] CMD_BYTE_LO  = 2'd2;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

endpackage

// File: rtl/uart_trx.sv
// 8N1 UART transceiver: independent receive and transmit state machines.
module uart_trx
    import uart_comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       rx_busy,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_done
);

    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(BAUD_DIV / 2 - 1);

    rx_state_e         rx_state_q;
    logic              rx_s1_q, rx_s2_q, rx_prev_q;
    logic [BAUD_W-1:0] rx_cnt_q;
    logic [2:0]        rx_bit_q;
    logic [7:0]        rx_sh_q, rx_data_q;
    logic              rx_rdy_q;

    tx_state_e         tx_state_q;
    logic              tx_q;
    logic [BAUD_W-1:0] tx_cnt_q;
    logic [2:0]        tx_bit_q;
    logic [7:0]        tx_sh_q;
    logic              tx_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_rdy_q   <= 1'b0;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_rdy_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    // Line back high at mid-start means it was only a glitch
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                        if (rx_s2_q) begin
                            rx_data_q <= rx_sh_q;
                            rx_rdy_q  <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    // A request landing on the completion cycle is dropped
                    if (tx_start && !tx_done_q) begin
                        tx_sh_q    <= tx_data;
                        tx_q       <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_sh_q[0];
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_bit_q <= tx_bit_q + 3'd1;
                            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                            tx_q     <= tx_sh_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_done_q  <= 1'b1;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx      = tx_q;
    assign rx_data = rx_data_q;
    assign rx_rdy  = rx_rdy_q;
    assign rx_busy = (rx_state_q != RX_IDLE);
    assign tx_done = tx_done_q;

endmodule

// File: rtl/uart_comm.sv
// UART host link: assembles 3-byte commands from RX and sends response bytes on TX.
module uart_comm
    import uart_comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV     = DEF_BAUD_DIV,
    parameter int unsigned TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp_data,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam int unsigned TO_CYC = TIMEOUT_BITS * BAUD_DIV;
    localparam int unsigned TO_W   = $clog2(TO_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    logic [7:0]      rx_data;
    logic            rx_rdy, rx_busy;

    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]      b0_q, b0_d, b1_q, b1_d;
    logic [23:0]     cmd_q, cmd_d;
    logic            cmd_rdy_q, cmd_rdy_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    uart_trx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_trx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (RX),
        .tx       (TX),
        .rx_data  (rx_data),
        .rx_rdy   (rx_rdy),
        .rx_busy  (rx_busy),
        .tx_start (send_resp),
        .tx_data  (resp_data),
        .tx_done  (resp_sent)
    );

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        to_cnt_d   = to_cnt_q;

        if (clr_cmd_rdy) cmd_rdy_d = 1'b0;

        if (rx_rdy && !cmd_rdy_q) begin
            to_cnt_d = '0;
            case (byte_cnt_q)
                CMD_BYTE_HI: begin
                    b0_d       = rx_data;
                    byte_cnt_d = CMD_BYTE_MID;
                end
                CMD_BYTE_MID: begin
                    b1_d       = rx_data;
                    byte_cnt_d = CMD_BYTE_LO;
                end
                CMD_BYTE_LO: begin
                    cmd_d      = {b0_q, b1_q, rx_data};
                    cmd_rdy_d  = 1'b1;
                    byte_cnt_d = CMD_BYTE_HI;
                end
                default: byte_cnt_d = CMD_BYTE_HI;
            endcase
        end else if (byte_cnt_q == CMD_BYTE_HI || rx_busy) begin
            // Timeout measures idle line time only, so a byte in flight never expires it
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            to_cnt_d   = '0;
            byte_cnt_d = CMD_BYTE_HI;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= CMD_BYTE_HI;
            b0_q       <= '0;
            b1_q       <= '0;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

endmodule
